bus_rr_arbiter: RTL and testbench
=================================

# bus_rr_arbiter

Two-master, round-robin bus arbiter with serial slave-address capture, transaction tracking and an optional watchdog. It sits between the two bus masters and the master/slave select muxes of the system bus. It drives `bus_grant` to the master mux and `slave_grant` to the slave mux. It holds ownership from grant until the slave signals completion, the master drops its request, or the watchdog expires.

## Interface
- `TIMEOUT_CYCLES`, 64: cycles allowed in ACTIVE without `slave_done` before a forced release. Legal range 2..65535; counter width is `$clog2(TIMEOUT_CYCLES)`.
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `m1_request` input 1: master 1 bus request, held high for its whole transaction.
- `m2_request` input 1: master 2 bus request, held high for its whole transaction.
- `m1_slave_select` input 1: master 1 serial slave-address line.
- `m2_slave_select` input 1: master 2 serial slave-address line.
- `slave_done` input 1: one-cycle pulse from the addressed slave; transaction complete.
- `m1_grant` output 1: master 1 owns the bus.
- `m2_grant` output 1: master 2 owns the bus.
- `busy` output 1: bus in use; high in ADDR and ACTIVE.
- `slave_grant` output 2: captured slave address to the slave select mux.
- `bus_grant` output 2: master mux select; 01 = master 1, 10 = master 2, 00 = none.
- `timeout` output 1: one-cycle pulse on watchdog release.

## Operation
- All outputs are registered.
- Reset values:
  - Outputs: all 0.
  - State: IDLE.
  - Internal: `last_owner` = master 2, so master 1 wins the first contention; bit counter 0; watchdog counter 0.
- States: IDLE, ADDR, ACTIVE, RELEASE.
- **IDLE**
  - Grants 0, `busy` 0, `slave_grant` holds its last value.
  - With only one request high, that master is granted.
  - With both high, the master that is not `last_owner` is granted.
  - On grant: go to ADDR; set `mX_grant`=1, `bus_grant`, `busy`=1 and `last_owner` on the same edge.
- **ADDR**
  - Only the owner's `mX_slave_select` is sampled.
  - Frame: a start bit (1) first, then 2 address bits, LSB first. Line low while waiting for the start bit means idle.
  - `slave_grant` updates once, with both bits, on the edge that samples bit 1; the state goes to ACTIVE on the same edge.
  - Owner request low in ADDR: abort to RELEASE; `slave_grant` is unchanged.
- **ACTIVE**
  - `busy` 1 and grants held.
  - Exits to RELEASE on any of:
    - `slave_done`=1;
    - owner request low;
    - watchdog expiry (sets `timeout`=1 for one cycle).
  - Priority when exits coincide: `slave_done` > request drop > timeout. `timeout` does not pulse if `slave_done` arrives in the expiry cycle.
- **RELEASE**
  - One bus-turnaround cycle: grants 0, `bus_grant` 00, `busy` 0.
  - Always goes to IDLE next. No arbitration takes place in RELEASE.
- Requests from the non-owner are ignored until IDLE. There is no preemption.
- `slave_done` outside ACTIVE is ignored.
- Watchdog:
  - Clears on ACTIVE entry and increments each ACTIVE cycle without `slave_done`.
  - Expires in the cycle the count reaches `TIMEOUT_CYCLES`-1, i.e. the `TIMEOUT_CYCLES`-th ACTIVE cycle.
- Reset low at any time: immediate return to reset values. A partial address frame is discarded.

## Timing
- Grant latency: request sampled high in IDLE at edge N gives `mX_grant` high after edge N.
- Address capture: start bit at edge S, bit0 at S+1, bit1 at S+2. `slave_grant` is valid and state is ACTIVE after edge S+2.
- Release: a terminating event sampled at edge E gives grants low after E. The earliest next grant is after E+2 (RELEASE, then IDLE arbitration).
- Back-to-back with both requests held: ownership alternates m1, m2, m1, …
- Minimum transaction with start bit immediately after grant is 1 ADDR-start cycle + 2 bit cycles + 1 ACTIVE cycle + RELEASE.

## Configuration
- `BUS_ARB_TIMEOUT_EN`
  - Defined: watchdog counter and `timeout` logic are present as described.
  - Undefined: no counter. `timeout` is tied 0. ACTIVE exits only on `slave_done` or request drop, and `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset low mid-ACTIVE with m1 owning and `slave_grant`=10 -> all outputs 0 immediately; after release, first contention with m1 and m2 both high grants m1.
- m1 only, frame 1,1,0 (start, bit0=1, bit1=0) -> `slave_grant`=01 after the third bit edge; `slave_done` pulse -> one RELEASE cycle with `bus_grant`=00 and `busy`=0, then IDLE.
- m1 and m2 held high continuously, each completing via `slave_done` -> `bus_grant` sequence 01, 10, 01, 10 with one 00 cycle between owners.
- m2 owns, drops its request during ADDR after the start bit -> RELEASE next cycle, `slave_grant` keeps its prior value, no `timeout`.
- With `BUS_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: hold ACTIVE with no `slave_done` -> `timeout` pulses once on the 8th ACTIVE cycle and grants drop; same stimulus with the macro undefined -> grant held indefinitely, `timeout` stays 0.
- `slave_done` and watchdog expiry in the same cycle -> RELEASE and `timeout` stays 0.

Source files
------------

// File: rtl/bus_rr_arbiter_if.sv
// Bus-side signal bundle for bus_rr_arbiter.
// slave modport: arbiter view. master modport: request/select driver view.
interface bus_rr_arbiter_if;
  logic       m1_request;
  logic       m2_request;
  logic       m1_slave_select;
  logic       m2_slave_select;
  logic       slave_done;
  logic       m1_grant;
  logic       m2_grant;
  logic       busy;
  logic [1:0] slave_grant;
  logic [1:0] bus_grant;
  logic       timeout;

  modport master (
    output m1_request, m2_request, m1_slave_select, m2_slave_select, slave_done,
    input  m1_grant, m2_grant, busy, slave_grant, bus_grant, timeout
  );

  modport slave (
    input  m1_request, m2_request, m1_slave_select, m2_slave_select, slave_done,
    output m1_grant, m2_grant, busy, slave_grant, bus_grant, timeout
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Two-master round-robin bus arbiter with serial slave-address capture.
// Define BUS_ARB_TIMEOUT_EN to include the ACTIVE-state watchdog and timeout pulse.
module bus_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic            clk,
  input logic            reset,
  bus_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADDR, ACTIVE, RELEASE} state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_rr_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

  state_t     state, state_d;
  logic       last_owner, last_owner_d;   // 0 = master 1, 1 = master 2
  logic [1:0] bit_cnt, bit_cnt_d;         // 0 = await start, 1 = bit0, 2 = bit1
  logic       addr_lo, addr_lo_d;
  logic       m1_grant_q, m1_grant_d;
  logic       m2_grant_q, m2_grant_d;
  logic       busy_q, busy_d;
  logic [1:0] slave_grant_q, slave_grant_d;
  logic [1:0] bus_grant_q, bus_grant_d;
  logic       timeout_q, timeout_d;
  logic       owner_req_c;
  logic       owner_sel_c;
  logic       wd_expire_c;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt, wd_cnt_d;
  assign wd_expire_c = (wd_cnt == WD_LAST);
`else
  assign wd_expire_c = 1'b0;
`endif

  // Only the current owner's request and address line matter once granted.
  assign owner_req_c = last_owner ? bus.m2_request      : bus.m1_request;
  assign owner_sel_c = last_owner ? bus.m2_slave_select : bus.m1_slave_select;

  always_comb begin
    state_d       = state;
    last_owner_d  = last_owner;
    bit_cnt_d     = bit_cnt;
    addr_lo_d     = addr_lo;
    m1_grant_d    = m1_grant_q;
    m2_grant_d    = m2_grant_q;
    busy_d        = busy_q;
    slave_grant_d = slave_grant_q;
    bus_grant_d   = bus_grant_q;
    timeout_d     = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    wd_cnt_d      = wd_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (bus.m1_request && (!bus.m2_request || last_owner)) begin
          state_d      = ADDR;
          last_owner_d = 1'b0;
          m1_grant_d   = 1'b1;
          bus_grant_d  = 2'b01;
          busy_d       = 1'b1;
          bit_cnt_d    = 2'd0;
        end else if (bus.m2_request) begin
          state_d      = ADDR;
          last_owner_d = 1'b1;
          m2_grant_d   = 1'b1;
          bus_grant_d  = 2'b10;
          busy_d       = 1'b1;
          bit_cnt_d    = 2'd0;
        end
      end
      ADDR: begin
        if (!owner_req_c) begin
          state_d = RELEASE;
        end else begin
          unique case (bit_cnt)
            2'd0: if (owner_sel_c) bit_cnt_d = 2'd1;
            2'd1: begin
              addr_lo_d = owner_sel_c;
              bit_cnt_d = 2'd2;
            end
            default: begin
              slave_grant_d = {owner_sel_c, addr_lo};
              bit_cnt_d     = 2'd0;
              state_d       = ACTIVE;
`ifdef BUS_ARB_TIMEOUT_EN
              wd_cnt_d      = '0;
`endif
            end
          endcase
        end
      end
      ACTIVE: begin
        // slave_done outranks request drop, which outranks the watchdog.
        if (bus.slave_done || !owner_req_c) begin
          state_d = RELEASE;
        end else if (wd_expire_c) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else begin
          wd_cnt_d = wd_cnt + WD_W'(1);
        end
`endif
      end
      RELEASE: state_d = IDLE;
    endcase

    if (state_d == RELEASE) begin
      m1_grant_d  = 1'b0;
      m2_grant_d  = 1'b0;
      busy_d      = 1'b0;
      bus_grant_d = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_owner    <= 1'b1;
      bit_cnt       <= 2'd0;
      addr_lo       <= 1'b0;
      m1_grant_q    <= 1'b0;
      m2_grant_q    <= 1'b0;
      busy_q        <= 1'b0;
      slave_grant_q <= 2'b00;
      bus_grant_q   <= 2'b00;
      timeout_q     <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      wd_cnt        <= '0;
`endif
    end else begin
      state         <= state_d;
      last_owner    <= last_owner_d;
      bit_cnt       <= bit_cnt_d;
      addr_lo       <= addr_lo_d;
      m1_grant_q    <= m1_grant_d;
      m2_grant_q    <= m2_grant_d;
      busy_q        <= busy_d;
      slave_grant_q <= slave_grant_d;
      bus_grant_q   <= bus_grant_d;
      timeout_q     <= timeout_d;
`ifdef BUS_ARB_TIMEOUT_EN
      wd_cnt        <= wd_cnt_d;
`endif
    end
  end

  assign bus.m1_grant    = m1_grant_q;
  assign bus.m2_grant    = m2_grant_q;
  assign bus.busy        = busy_q;
  assign bus.slave_grant = slave_grant_q;
  assign bus.bus_grant   = bus_grant_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: per-cycle expected outputs are queued
// as stimulus is driven and compared at the following falling edge.
module tb_bus_rr_arbiter;

  localparam int unsigned TO = 8;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [1:0] sg;
  logic [1:0] addrs [4];

  always #5 clk = ~clk;

  bus_rr_arbiter_if bus ();

  bus_rr_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %b required %b (g1 g2 busy sg[1:0] bg[1:0] to)", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_v();
    return {bus.m1_grant, bus.m2_grant, bus.busy, bus.slave_grant, bus.bus_grant, bus.timeout};
  endfunction

  // Expected output vector; busy and bus_grant follow the grants by definition.
  function automatic logic [7:0] ex(input logic g1, input logic g2, input logic to,
                                    input logic [1:0] s);
    return {g1, g2, g1 | g2, s, g2, g1, to};
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check_eq(mon_e.tag, obs_v(), mon_e.v);
    end
  end

  task automatic cyc(input logic r1, input logic r2, input logic s1, input logic s2,
                     input logic dn, input logic [7:0] e, input string tag);
    exp_t item;
    @(negedge clk);
    #1;
    bus.m1_request      = r1;
    bus.m2_request      = r2;
    bus.m1_slave_select = s1;
    bus.m2_slave_select = s2;
    bus.slave_done      = dn;
    item.tag = tag;
    item.v   = e;
    sb_q.push_back(item);
    @(posedge clk);
  endtask

  // Grant plus start/bit0/bit1 frame; the non-owner line carries the inverse bit.
  task automatic addr_phase(input logic r1, input logic r2, input logic owner2,
                            input logic [1:0] a, input string tag);
    logic g1, g2;
    logic [2:0] frame;
    g1 = !owner2;
    g2 = owner2;
    frame = {a[1], a[0], 1'b1};
    cyc(r1, r2, 1'b0, 1'b0, 1'b0, ex(g1, g2, 1'b0, sg), {tag, "_grant"});
    for (int b = 0; b < 3; b++) begin
      if (b == 2) sg = a;
      cyc(r1, r2, owner2 ? !frame[b] : frame[b], owner2 ? frame[b] : !frame[b], 1'b0,
          ex(b == 2 ? g1 : g1, b == 2 ? g2 : g2, 1'b0, sg),
          b == 0 ? {tag, "_start"} : (b == 1 ? {tag, "_bit0"} : {tag, "_bit1"}));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: observed no finish required finish");
    $fatal(1, "time limit");
  end

  initial begin
    sg = 2'b00;
    addrs = '{2'b10, 2'b11, 2'b00, 2'b01};
    bus.m1_request = 1'b0;
    bus.m2_request = 1'b0;
    bus.m1_slave_select = 1'b0;
    bus.m2_slave_select = 1'b0;
    bus.slave_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_eq("reset_outs", obs_v(), 8'h00);
    @(negedge clk) reset = 1'b1;

    // m1 alone, frame 1,1,0 -> slave 01, then slave_done
    addr_phase(1'b1, 1'b0, 1'b0, 2'b01, "a");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 1'b0, sg), "a_done");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "a_release");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "a_idle");

    // m2 alone, stray slave_done in ADDR, request dropped after start bit
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b1, 1'b0, sg), "d_grant");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, ex(1'b0, 1'b1, 1'b0, sg), "d_start");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "d_abort");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "d_idle");

    // both held: ownership alternates m1, m2, m1, m2
    for (int i = 0; i < 4; i++) begin
      addr_phase(1'b1, 1'b1, (i % 2) == 1, addrs[i], "b");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 1'b0, sg), "b_done");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "b_release");
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "b_idle");

    // m2 drops its request while ACTIVE
    addr_phase(1'b0, 1'b1, 1'b1, 2'b11, "g");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "g_drop");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "g_idle");

    // ACTIVE held with no slave_done
    addr_phase(1'b1, 1'b0, 1'b0, 2'b10, "e");
`ifdef BUS_ARB_TIMEOUT_EN
    for (int k = 1; k < TO; k++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, 1'b0, 1'b0, sg), "e_active");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b1, sg), "e_timeout");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "e_release");
`else
    for (int k = 1; k <= 3 * TO; k++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, 1'b0, 1'b0, sg), "e_held");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 1'b0, sg), "e_done");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "e_release");
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "e_idle");

    // slave_done lands in the would-be expiry cycle
    addr_phase(1'b1, 1'b0, 1'b0, 2'b11, "f");
    for (int k = 1; k < TO; k++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, 1'b0, 1'b0, sg), "f_active");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 1'b0, sg), "f_done_at_expiry");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "f_release");

    // asynchronous reset mid-ACTIVE with m1 owning slave 10
    addr_phase(1'b1, 1'b0, 1'b0, 2'b10, "r");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, 1'b0, 1'b0, sg), "r_active");
    @(negedge clk);
    #2 reset = 1'b0;
    bus.m2_request = 1'b1;
    #1 check_eq("rst_async", obs_v(), 8'h00);
    sg = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_hold", obs_v(), 8'h00);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, 1'b0, 1'b0, sg), "r_first_contention");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "r_abort");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, sg), "r_idle");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) check_eq("sb_drain", 8'(sb_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
